cpu_sequencer: RTL and testbench

Multi-cycle control sequencer for the 8-bit CPU core. It steps each instruction through fetch, decode, execute and writeback. It issues the instruction-memory request and the instruction-register, register-file and program-counter write strobes, and it selects the next PC source between pc+1 and the branch target. It sits between the decoder/ALU and the PC/IR/register-file datapath, and adds run/single-step control, halt handling and a fetch timeout for board bring-up.

---
 rtl/cpu_sequencer.sv | 132 +++++++++++++
 tb/tb_cpu_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the 8-bit CPU core.
// Steps each instruction through FETCH -> DECODE -> EXEC -> WB and issues the
// datapath strobes. It also provides run/single-step control, sticky HALT
// handling and a fetch timeout that parks the core in ERR.
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 15,  // consecutive un-acked FETCH cycles before ERR (1..255)
  parameter int CNT_W       = 16   // retired-instruction counter width
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active-low
  input  logic             run,
  input  logic             step,
  input  logic             imem_ack,
  input  logic             halt_op,
  input  logic             is_branch,
  input  logic             br_cond,
  output logic             imem_req,
  output logic             ir_we,
  output logic             reg_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic [2:0]       state,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  // Timeout count value seen on the last allowed un-acked FETCH cycle.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [7:0]       tmo_reg;
  logic             step_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             fetch_reg;
  logic             wb_reg;
  logic             halted_reg;
  logic             mem_err_reg;

  // Next-state decode; run has priority over step in IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (run || step) state_next = S_FETCH;
      end
      S_FETCH: begin
        // An ack on the final timeout cycle still wins over the error.
        if (imem_ack)                 state_next = S_DECODE;
        else if (tmo_reg == TMO_LAST) state_next = S_ERR;
      end
      S_DECODE: state_next = halt_op ? S_HALT : S_EXEC;
      S_EXEC:   state_next = S_WB;
      S_WB:     state_next = (step_reg || !run) ? S_IDLE : S_FETCH;
      S_HALT:   state_next = S_HALT;
      S_ERR:    state_next = S_ERR;
      default:  state_next = S_IDLE;
    endcase
  end

  // State register plus registered Moore flags derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      fetch_reg   <= 1'b0;
      wb_reg      <= 1'b0;
      halted_reg  <= 1'b0;
      mem_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      fetch_reg   <= (state_next == S_FETCH);
      wb_reg      <= (state_next == S_WB);
      halted_reg  <= (state_next == S_HALT);
      mem_err_reg <= (state_next == S_ERR);
    end
  end

  // Fetch timeout: cleared whenever outside FETCH, so every FETCH entry starts at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_reg <= 8'd0;
    end else if (state_reg != S_FETCH) begin
      tmo_reg <= 8'd0;
    end else if (!imem_ack) begin
      tmo_reg <= tmo_reg + 8'd1;
    end
  end

  // Single-step flag: latched only when step alone starts an instruction, dropped leaving WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_reg <= 1'b0;
    end else if (state_reg == S_IDLE && !run && step) begin
      step_reg <= 1'b1;
    end else if (state_reg == S_WB) begin
      step_reg <= 1'b0;
    end
  end

  // Retired-instruction counter; bumps at the same edge as the PC write, wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (state_reg == S_WB) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Output strobes. ir_we is Mealy on the ack. reg_we and pc_src qualify the
  // registered WB flag with decoder/ALU inputs that are only valid in WB.
  assign imem_req  = fetch_reg;
  assign ir_we     = (state_reg == S_FETCH) && imem_ack;
  assign pc_we     = wb_reg;
  assign reg_we    = wb_reg && !is_branch;
  assign pc_src    = wb_reg && is_branch && br_cond;
  assign state     = state_reg;
  assign halted    = halted_reg;
  assign mem_err   = mem_err_reg;
  assign instr_cnt = cnt_reg;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed testbench for cpu_sequencer. A second instance with a 3-bit
// counter shares all inputs so that counter wrap is reachable in a short run.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run, step, imem_ack, halt_op, is_branch, br_cond;
  logic        imem_req, ir_we, reg_we, pc_we, pc_src, halted, mem_err;
  logic [2:0]  state;
  logic [15:0] instr_cnt;
  logic        w_imem_req, w_ir_we, w_reg_we, w_pc_we, w_pc_src, w_halted, w_mem_err;
  logic [2:0]  w_state;
  logic [2:0]  w_instr_cnt;

  int checks = 0;
  int passes = 0;

  cpu_sequencer #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .imem_ack(imem_ack),
    .halt_op(halt_op), .is_branch(is_branch), .br_cond(br_cond),
    .imem_req(imem_req), .ir_we(ir_we), .reg_we(reg_we), .pc_we(pc_we),
    .pc_src(pc_src), .state(state), .halted(halted), .mem_err(mem_err),
    .instr_cnt(instr_cnt)
  );

  cpu_sequencer #(.MEM_TIMEOUT(15), .CNT_W(3)) dut_w (
    .clk(clk), .rst(rst), .run(run), .step(step), .imem_ack(imem_ack),
    .halt_op(halt_op), .is_branch(is_branch), .br_cond(br_cond),
    .imem_req(w_imem_req), .ir_we(w_ir_we), .reg_we(w_reg_we), .pc_we(w_pc_we),
    .pc_src(w_pc_src), .state(w_state), .halted(w_halted), .mem_err(w_mem_err),
    .instr_cnt(w_instr_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; run = 1'b0; step = 1'b0; imem_ack = 1'b0;
    halt_op = 1'b0; is_branch = 1'b0; br_cond = 1'b0;
    tick(); tick();
    checks++; if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else passes++;
    checks++; if ({imem_req, ir_we, reg_we, pc_we, pc_src, halted, mem_err} !== 7'b0)
      $display("FAIL reset_strobes: got %b want 0000000", {imem_req, ir_we, reg_we, pc_we, pc_src, halted, mem_err});
    else passes++;
    checks++; if (instr_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", instr_cnt); else passes++;
    rst = 1'b1;
    tick();
    checks++; if (state !== 3'd0) $display("FAIL idle_hold: got %0d want 0", state); else passes++;
    $display("test_reset done");
  endtask

  task automatic test_free_run;
    logic [2:0] exp_st;
    imem_ack = 1'b1; is_branch = 1'b0; run = 1'b1;
    tick();  // cycle 1 = first FETCH
    checks++; if ({imem_req, ir_we} !== 2'b11) $display("FAIL fetch_strobes: got %b want 11", {imem_req, ir_we}); else passes++;
    for (int k = 1; k <= 12; k++) begin
      exp_st = 3'((k - 1) % 4 + 1);
      checks++; if (state !== exp_st) $display("FAIL run_state c%0d: got %0d want %0d", k, state, exp_st); else passes++;
      checks++; if (pc_we !== (k % 4 == 0)) $display("FAIL run_pc_we c%0d: got %b want %b", k, pc_we, (k % 4 == 0)); else passes++;
      checks++; if (reg_we !== (k % 4 == 0)) $display("FAIL run_reg_we c%0d: got %b want %b", k, reg_we, (k % 4 == 0)); else passes++;
      if (k == 12) run = 1'b0;
      tick();
    end
    checks++; if (state !== 3'd0) $display("FAIL run_stop_idle: got %0d want 0", state); else passes++;
    checks++; if (instr_cnt !== 16'd3) $display("FAIL run_cnt: got %0d want 3", instr_cnt); else passes++;
    $display("test_free_run done cnt=%0d", instr_cnt);
  endtask

  task automatic test_branch(input logic cond);
    run = 1'b1; imem_ack = 1'b1; is_branch = 1'b1; br_cond = cond;
    tick(); tick(); tick();  // FETCH, DECODE, EXEC
    checks++; if (pc_src !== 1'b0) $display("FAIL br_exec_pc_src: got %b want 0", pc_src); else passes++;
    tick();  // WB
    checks++; if ({pc_we, reg_we, pc_src} !== {1'b1, 1'b0, cond})
      $display("FAIL br_wb cond=%b: got pc_we/reg_we/pc_src=%b want %b", cond, {pc_we, reg_we, pc_src}, {1'b1, 1'b0, cond});
    else passes++;
    run = 1'b0;
    tick();
    checks++; if ({state, pc_src} !== 4'b0000) $display("FAIL br_after: got state/pc_src=%b want 0000", {state, pc_src}); else passes++;
    is_branch = 1'b0; br_cond = 1'b0;
    $display("test_branch cond=%b done", cond);
  endtask

  task automatic test_run_step_both;
    run = 1'b1; step = 1'b1;
    tick();
    step = 1'b0;
    tick(); tick(); tick();  // WB
    tick();
    checks++; if (state !== 3'd1) $display("FAIL both_continue: got %0d want 1", state); else passes++;
    run = 1'b0;
    tick(); tick(); tick(); tick();
    checks++; if (state !== 3'd0) $display("FAIL both_stop: got %0d want 0", state); else passes++;
    checks++; if (instr_cnt !== 16'd7) $display("FAIL both_cnt: got %0d want 7", instr_cnt); else passes++;
    $display("test_run_step_both done cnt=%0d", instr_cnt);
  endtask

  task automatic test_single_step;
    run = 1'b0; step = 1'b1;
    tick();
    checks++; if (state !== 3'd1) $display("FAIL ss_fetch: got %0d want 1", state); else passes++;
    step = 1'b0;
    tick();
    checks++; if (state !== 3'd2) $display("FAIL ss_decode: got %0d want 2", state); else passes++;
    step = 1'b1;  // ignored mid-instruction
    tick();
    step = 1'b0;
    tick();
    checks++; if ({state, pc_we} !== {3'd4, 1'b1}) $display("FAIL ss_wb: got state/pc_we=%b want 1001", {state, pc_we}); else passes++;
    tick();
    checks++; if (state !== 3'd0) $display("FAIL ss_idle: got %0d want 0", state); else passes++;
    tick();
    checks++; if (state !== 3'd0) $display("FAIL ss_no_second: got %0d want 0", state); else passes++;
    checks++; if (instr_cnt !== 16'd8) $display("FAIL ss_cnt: got %0d want 8", instr_cnt); else passes++;
    checks++; if (w_instr_cnt !== 3'd0) $display("FAIL ss_wrap3: got %0d want 0", w_instr_cnt); else passes++;
    $display("test_single_step done cnt=%0d", instr_cnt);
  endtask

  task automatic test_timeout_ack_last;
    imem_ack = 1'b0; run = 1'b1;
    tick();
    for (int k = 1; k <= 15; k++) begin
      checks++; if (state !== 3'd1) $display("FAIL tmo_ack_wait c%0d: got %0d want 1", k, state); else passes++;
      if (k < 15) tick();
    end
    imem_ack = 1'b1;
    #1;
    checks++; if (ir_we !== 1'b1) $display("FAIL tmo_ack_ir_we: got %b want 1", ir_we); else passes++;
    run = 1'b0;
    tick();
    checks++; if ({state, mem_err} !== {3'd2, 1'b0}) $display("FAIL tmo_ack_decode: got state/mem_err=%b want 0100", {state, mem_err}); else passes++;
    tick(); tick(); tick();
    checks++; if (instr_cnt !== 16'd9) $display("FAIL tmo_ack_cnt: got %0d want 9", instr_cnt); else passes++;
    $display("test_timeout_ack_last done");
  endtask

  task automatic test_timeout_err;
    imem_ack = 1'b0; run = 1'b1;
    tick();
    for (int k = 1; k <= 15; k++) begin
      checks++; if (state !== 3'd1) $display("FAIL tmo_wait c%0d: got %0d want 1", k, state); else passes++;
      tick();
    end
    checks++; if ({state, mem_err, imem_req} !== {3'd6, 1'b1, 1'b0})
      $display("FAIL tmo_err: got state/mem_err/imem_req=%b want 11010", {state, mem_err, imem_req});
    else passes++;
    run = 1'b0; tick();
    run = 1'b1; tick();
    imem_ack = 1'b1; tick();
    checks++; if ({state, mem_err, ir_we} !== {3'd6, 1'b1, 1'b0})
      $display("FAIL tmo_absorb: got state/mem_err/ir_we=%b want 11010", {state, mem_err, ir_we});
    else passes++;
    $display("test_timeout_err done");
  endtask

  task automatic test_halt;
    rst = 1'b0; run = 1'b0; imem_ack = 1'b0;
    #1;
    checks++; if ({state, mem_err} !== 4'b0000) $display("FAIL async_clr_err: got %b want 0000", {state, mem_err}); else passes++;
    tick();
    rst = 1'b1;
    imem_ack = 1'b1; halt_op = 1'b1; run = 1'b1;
    tick(); tick();
    checks++; if ({state, pc_we} !== {3'd2, 1'b0}) $display("FAIL halt_decode: got %b want 0100", {state, pc_we}); else passes++;
    tick();
    checks++; if ({state, halted, pc_we} !== {3'd5, 1'b1, 1'b0}) $display("FAIL halt_enter: got %b want 10110", {state, halted, pc_we}); else passes++;
    checks++; if (instr_cnt !== 16'd0) $display("FAIL halt_cnt: got %0d want 0", instr_cnt); else passes++;
    halt_op = 1'b0;
    for (int k = 0; k < 4; k++) begin
      run = ~run;
      tick();
      checks++; if ({state, halted, pc_we, imem_req} !== {3'd5, 1'b1, 1'b0, 1'b0})
        $display("FAIL halt_absorb %0d: got %b want 101100", k, {state, halted, pc_we, imem_req});
      else passes++;
    end
    rst = 1'b0;
    #1;
    checks++; if ({state, halted} !== 4'b0000) $display("FAIL halt_rst: got %b want 0000", {state, halted}); else passes++;
    run = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    $display("test_halt done");
  endtask

  task automatic test_run_drop_exec;
    run = 1'b1; imem_ack = 1'b1; halt_op = 1'b0; is_branch = 1'b0;
    tick();
    repeat (28) tick();
    checks++; if (state !== 3'd1) $display("FAIL drop_fetch8: got %0d want 1", state); else passes++;
    tick(); tick();
    checks++; if ({state, w_instr_cnt} !== {3'd3, 3'd7}) $display("FAIL drop_exec: got state/wcnt=%b want 011111", {state, w_instr_cnt}); else passes++;
    run = 1'b0;
    tick();
    checks++; if ({state, pc_we} !== {3'd4, 1'b1}) $display("FAIL drop_wb: got %b want 1001", {state, pc_we}); else passes++;
    tick();
    checks++; if (state !== 3'd0) $display("FAIL drop_idle: got %0d want 0", state); else passes++;
    checks++; if (instr_cnt !== 16'd8) $display("FAIL drop_cnt: got %0d want 8", instr_cnt); else passes++;
    checks++; if (w_instr_cnt !== 3'd0) $display("FAIL drop_wrap: got %0d want 0", w_instr_cnt); else passes++;
    $display("test_run_drop_exec done cnt=%0d wcnt=%0d", instr_cnt, w_instr_cnt);
  endtask

  task automatic test_async_abort;
    run = 1'b1; imem_ack = 1'b1;
    tick(); tick(); tick(); tick();  // WB
    checks++; if (pc_we !== 1'b1) $display("FAIL abort_pre_wb: got %b want 1", pc_we); else passes++;
    rst = 1'b0;
    #1;
    checks++; if ({state, pc_we, reg_we, imem_req, ir_we} !== 7'b0)
      $display("FAIL abort_now: got %b want 0000000", {state, pc_we, reg_we, imem_req, ir_we});
    else passes++;
    run = 1'b0;
    tick();
    checks++; if (instr_cnt !== 16'd0) $display("FAIL abort_cnt: got %0d want 0", instr_cnt); else passes++;
    rst = 1'b1;
    tick();
    $display("test_async_abort done");
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_branch(1'b1);
    test_branch(1'b0);
    test_run_step_both();
    test_single_step();
    test_timeout_ack_last();
    test_timeout_err();
    test_halt();
    test_run_drop_exec();
    test_async_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
